psr_bank: RTL and testbench

//  Stores the architectural CPSR and the five banked SPSRs (FIQ/IRQ/SVC/ABT/UND); consumes the 11-bit packed PSR
//  {N,Z,C,V,I,F,M[4:0]} produced by the CPSR-update logic. Drives the unpacked 32-bit CPSR and the current mode's SPSR.

---
 rtl/psr_bank_pkg.sv | 31 +++
 rtl/psr_bank_psr_unpack.sv | 9 +
 rtl/psr_bank.sv | 130 +++++++++++++
 tb/tb_psr_bank.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/psr_bank_pkg.sv
// psr_bank_pkg: mode encodings, PSR record layout, FSM states and mode helpers for psr_bank
package psr_bank_pkg;
  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;
  localparam int N_SPSR = 5;
  // Field order places T at bit 5 so the 12-bit record maps straight onto CPSR[7:0]
  typedef struct packed {
    logic [3:0] nzcv;
    logic       i;
    logic       f;
    logic       t;
    logic [4:0] m;
  } psr_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_SWITCH} state_e;
  function automatic logic has_spsr(input logic [4:0] m);
    return m inside {MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND};
  endfunction
  function automatic logic mode_legal(input logic [4:0] m);
    return has_spsr(m) || m == MODE_USR || m == MODE_SYS;
  endfunction
  // Bank slot for a mode; only meaningful when has_spsr(m)
  function automatic logic [2:0] spsr_idx(input logic [4:0] m);
    return m == MODE_FIQ ? 3'd0 : m == MODE_IRQ ? 3'd1 : m == MODE_SVC ? 3'd2 :
           m == MODE_ABT ? 3'd3 : 3'd4;
  endfunction
endpackage

// File: rtl/psr_bank_psr_unpack.sv
// psr_unpack: expands a 12-bit PSR record {NZCV,I,F,T,M} into the 32-bit architectural layout
//   psr_i  in  12  packed record (psr_bank_pkg::psr_t)
//   psr_o  out 32  [31:28]=NZCV [7]=I [6]=F [5]=T [4:0]=M, other bits 0
module psr_unpack (
  input  logic [11:0] psr_i,
  output logic [31:0] psr_o
);
  assign psr_o = {psr_i[11:8], 20'b0, psr_i[7:0]};
endmodule

// File: rtl/psr_bank.sv
// psr_bank: CPSR plus five banked SPSRs with exception entry/return sequencing
//   clk          in   1   core clock
//   nreset       in   1   asynchronous active-low reset
//   PB_psr_in    in   11  packed PSR {NZCV,I,F,M}
//   PB_t_in      in   1   Thumb bit, present only with PSR_BANK_THUMB_EN
//   PB_cpsr_we   in   1   write CPSR from PB_psr_in
//   PB_spsr_we   in   1   write current mode's SPSR from PB_psr_in
//   PB_exc_req   in   1   start exception entry into PB_exc_mode
//   PB_exc_mode  in   5   exception target mode
//   PB_ret_req   in   1   exception return, CPSR <= current SPSR
//   PB_busy      out  1   entry sequence in progress, requests ignored
//   PB_done      out  1   pulse on entry/return completion
//   PB_mode_err  out  1   pulse on illegal mode or SPSR access in USR/SYS
//   PB_cpsr_out  out  32  unpacked CPSR
//   PB_spsr_out  out  32  unpacked SPSR of current mode, 0 in USR/SYS
// Define PSR_BANK_THUMB_EN to add PB_t_in and keep a live T bit; otherwise T is constant 0.
module psr_bank
  import psr_bank_pkg::*;
#(
  parameter logic [4:0] RESET_MODE = 5'b10011
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [10:0] PB_psr_in,
`ifdef PSR_BANK_THUMB_EN
  input  logic        PB_t_in,
`endif
  input  logic        PB_cpsr_we,
  input  logic        PB_spsr_we,
  input  logic        PB_exc_req,
  input  logic [4:0]  PB_exc_mode,
  input  logic        PB_ret_req,
  output logic        PB_busy,
  output logic        PB_done,
  output logic        PB_mode_err,
  output logic [31:0] PB_cpsr_out,
  output logic [31:0] PB_spsr_out
);
  state_e     state_q, state_d;
  psr_t       cpsr_q, cpsr_d;
  psr_t       spsr_q [N_SPSR];
  psr_t       spsr_d [N_SPSR];
  logic [4:0] exc_mode_q, exc_mode_d;
  logic       done_q, done_d, err_q, err_d;
  logic       t_in, cur_has;
  logic [2:0] cur_idx;
  psr_t       in_psr, cur_spsr;
`ifdef PSR_BANK_THUMB_EN
  assign t_in = PB_t_in;
`else
  assign t_in = 1'b0;
`endif
  assign in_psr   = {PB_psr_in[10:5], t_in, PB_psr_in[4:0]};
  assign cur_has  = has_spsr(cpsr_q.m);
  assign cur_idx  = spsr_idx(cpsr_q.m);
  assign cur_spsr = cur_has ? spsr_q[cur_idx] : '0;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      cpsr_q     <= '{nzcv: 4'b0, i: 1'b1, f: 1'b1, t: 1'b0, m: RESET_MODE};
      spsr_q     <= '{default: '0};
      exc_mode_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpsr_q     <= cpsr_d;
      spsr_q     <= spsr_d;
      exc_mode_q <= exc_mode_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
  // Only banked modes are valid exception targets; anything else is rejected in IDLE
  always_comb begin
    state_d = state_q == ST_SAVE ? ST_SWITCH :
              (state_q == ST_IDLE && PB_exc_req && has_spsr(PB_exc_mode)) ? ST_SAVE : ST_IDLE;
  end
  always_comb begin
    cpsr_d     = cpsr_q;
    spsr_d     = spsr_q;
    exc_mode_d = exc_mode_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (state_q == ST_SAVE) begin
      spsr_d[spsr_idx(exc_mode_q)] = cpsr_q;
    end else if (state_q == ST_SWITCH) begin
      cpsr_d.m = exc_mode_q;
      cpsr_d.i = 1'b1;
      cpsr_d.f = cpsr_q.f | (exc_mode_q == MODE_FIQ);
      cpsr_d.t = 1'b0;
      done_d   = 1'b1;
    end else if (state_q == ST_IDLE) begin
      if (PB_exc_req) begin
        exc_mode_d = PB_exc_mode;
        err_d      = !has_spsr(PB_exc_mode);
      end else if (PB_ret_req) begin
        err_d = !cur_has;
        if (cur_has) begin
          cpsr_d = cur_spsr;
          done_d = 1'b1;
          if (!mode_legal(cur_spsr.m)) begin
            cpsr_d.m = cpsr_q.m;
            err_d    = 1'b1;
          end
        end
      end else begin
        // SPSR write targets the mode in force before any same-cycle CPSR write
        if (PB_spsr_we) begin
          if (cur_has) spsr_d[cur_idx] = in_psr;
          else err_d = 1'b1;
        end
        if (PB_cpsr_we) begin
          cpsr_d = in_psr;
          if (!mode_legal(in_psr.m)) begin
            cpsr_d.m = cpsr_q.m;
            err_d    = 1'b1;
          end
        end
      end
    end
  end
  always_comb begin
    PB_busy     = state_q != ST_IDLE;
    PB_done     = done_q;
    PB_mode_err = err_q;
  end
  psr_unpack u_cpsr (.psr_i(cpsr_q),   .psr_o(PB_cpsr_out));
  psr_unpack u_spsr (.psr_i(cur_spsr), .psr_o(PB_spsr_out));
endmodule

// File: tb/tb_psr_bank.sv
// tb_psr_bank: directed and randomized checks of psr_bank against a mode-indexed behavioural model
module tb_psr_bank;
`ifdef PSR_BANK_THUMB_EN
  localparam bit THUMB = 1'b1;
`else
  localparam bit THUMB = 1'b0;
`endif
  logic        clk = 1'b0, nreset = 1'b0;
  logic [10:0] psr_in = '0;
  logic        cwe = 0, swe = 0, exc = 0, ret = 0, t_in = 0;
  logic [4:0]  emode = '0;
  logic        busy, done, err;
  logic [31:0] cpsr_o, spsr_o;
  int checks = 0, failures = 0;
  logic [31:0] m_cpsr;
  logic [31:0] m_spsr [32];
  int          m_stage;
  logic [4:0]  m_tgt;
  logic        m_done, m_err;
  always #5 clk = ~clk;
  psr_bank dut (
    .clk(clk), .nreset(nreset), .PB_psr_in(psr_in),
`ifdef PSR_BANK_THUMB_EN
    .PB_t_in(t_in),
`endif
    .PB_cpsr_we(cwe), .PB_spsr_we(swe), .PB_exc_req(exc), .PB_exc_mode(emode),
    .PB_ret_req(ret), .PB_busy(busy), .PB_done(done), .PB_mode_err(err),
    .PB_cpsr_out(cpsr_o), .PB_spsr_out(spsr_o)
  );
  function automatic bit banked(input logic [4:0] m);
    return m == 5'h11 || m == 5'h12 || m == 5'h13 || m == 5'h17 || m == 5'h1B;
  endfunction
  function automatic bit legal(input logic [4:0] m);
    return banked(m) || m == 5'h10 || m == 5'h1F;
  endfunction
  function automatic logic [31:0] unpack(input logic [10:0] p, input logic t);
    return {p[10:7], 20'b0, p[6], p[5], t & THUMB, p[4:0]};
  endfunction
  function automatic logic [31:0] exp_spsr();
    return banked(m_cpsr[4:0]) ? m_spsr[m_cpsr[4:0]] : 32'h0;
  endfunction
  task automatic model_reset();
    m_cpsr = 32'h0000_00D3;
    foreach (m_spsr[i]) m_spsr[i] = '0;
    m_stage = 0; m_done = 0; m_err = 0;
  endtask
  task automatic model_update();
    logic [31:0] nxt;
    logic [4:0]  cur;
    cur = m_cpsr[4:0];
    m_done = 0; m_err = 0;
    if (m_stage == 1) begin
      m_spsr[m_tgt] = m_cpsr;
      m_stage = 2;
    end else if (m_stage == 2) begin
      m_cpsr = {m_cpsr[31:28], 20'b0, 1'b1, m_cpsr[6] | (m_tgt == 5'h11), 1'b0, m_tgt};
      m_stage = 0; m_done = 1;
    end else if (exc) begin
      if (banked(emode)) begin m_tgt = emode; m_stage = 1; end
      else m_err = 1;
    end else if (ret) begin
      if (banked(cur)) begin
        nxt = m_spsr[cur]; m_done = 1;
        if (!legal(nxt[4:0])) begin nxt[4:0] = cur; m_err = 1; end
        m_cpsr = nxt;
      end else m_err = 1;
    end else begin
      if (swe) begin
        if (banked(cur)) m_spsr[cur] = unpack(psr_in, t_in);
        else m_err = 1;
      end
      if (cwe) begin
        nxt = unpack(psr_in, t_in);
        if (!legal(nxt[4:0])) begin nxt[4:0] = cur; m_err = 1; end
        m_cpsr = nxt;
      end
    end
  endtask
  task automatic step(input bit e, input logic [4:0] em, input bit r, input bit cw, input bit sw,
                      input logic [10:0] p, input bit t);
    exc = e; emode = em; ret = r; cwe = cw; swe = sw; psr_in = p; t_in = t;
    @(posedge clk);
    model_update();
    #1;
    exc = 0; ret = 0; cwe = 0; swe = 0;
  endtask
  task automatic idle();
    step(0, 5'h0, 0, 0, 0, 11'h0, 0);
  endtask
  task automatic do_reset();
    nreset = 0;
    model_reset();
    #7;
    @(negedge clk);
    nreset = 1;
  endtask
  task automatic test_reset();
    nreset = 0;
    model_reset();
    #12;
    checks++; if (cpsr_o !== 32'h0000_00D3) begin failures++; $display("FAIL reset_cpsr got=%h exp=000000d3", cpsr_o); end
    checks++; if (spsr_o !== 32'h0) begin failures++; $display("FAIL reset_spsr got=%h exp=0", spsr_o); end
    checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err}); end
    @(negedge clk);
    nreset = 1;
  endtask
  task automatic test_cpsr_write();
    step(0, 5'h0, 0, 1, 0, 11'b1010_0_0_10000, 0);
    checks++; if (cpsr_o !== 32'hA000_0010) begin failures++; $display("FAIL cpsr_we got=%h exp=a0000010", cpsr_o); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL cpsr_we_err got=%b exp=0", err); end
    step(0, 5'h0, 0, 0, 1, 11'b1111_1_1_10011, 0);
    checks++; if (err !== 1'b1 || spsr_o !== 32'h0) begin failures++; $display("FAIL spsr_usr got err=%b spsr=%h exp err=1 spsr=0", err, spsr_o); end
    idle();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", err); end
  endtask
  task automatic test_exception();
    step(1, 5'h12, 0, 0, 0, 11'h0, 0);
    checks++; if (busy !== 1'b1 || cpsr_o !== 32'hA000_0010) begin failures++; $display("FAIL exc_accept got busy=%b cpsr=%h exp busy=1 cpsr=a0000010", busy, cpsr_o); end
    idle();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL exc_save got busy=%b done=%b exp 1 0", busy, done); end
    idle();
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL exc_done got busy=%b done=%b exp 0 1", busy, done); end
    checks++; if (cpsr_o !== 32'hA000_0092) begin failures++; $display("FAIL exc_cpsr got=%h exp=a0000092", cpsr_o); end
    checks++; if (spsr_o !== 32'hA000_0010) begin failures++; $display("FAIL exc_spsr got=%h exp=a0000010", spsr_o); end
    idle();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", done); end
  endtask
  task automatic test_return();
    step(0, 5'h0, 1, 0, 0, 11'h0, 0);
    checks++; if (cpsr_o !== 32'hA000_0010 || done !== 1'b1) begin failures++; $display("FAIL ret got cpsr=%h done=%b exp a0000010 1", cpsr_o, done); end
    checks++; if (spsr_o !== 32'h0) begin failures++; $display("FAIL ret_spsr got=%h exp=0", spsr_o); end
  endtask
  task automatic test_priority();
    step(1, 5'h11, 1, 1, 0, 11'h7FF, 0);
    checks++; if (busy !== 1'b1 || err !== 1'b0 || cpsr_o !== 32'hA000_0010) begin failures++; $display("FAIL prio got busy=%b err=%b cpsr=%h exp 1 0 a0000010", busy, err, cpsr_o); end
    idle(); idle();
    checks++; if (cpsr_o !== 32'hA000_00D1 || done !== 1'b1) begin failures++; $display("FAIL fiq_entry got cpsr=%h done=%b exp a00000d1 1", cpsr_o, done); end
  endtask
  task automatic test_illegal_mode();
    step(0, 5'h0, 0, 1, 0, 11'b0101_0_0_00101, 0);
    checks++; if (cpsr_o !== 32'h5000_0011 || err !== 1'b1) begin failures++; $display("FAIL bad_mode got cpsr=%h err=%b exp 50000011 1", cpsr_o, err); end
    step(1, 5'h1F, 0, 0, 0, 11'h0, 0);
    checks++; if (busy !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL exc_sys got busy=%b err=%b exp 0 1", busy, err); end
  endtask
  task automatic test_busy_ignore();
    step(1, 5'h13, 0, 0, 0, 11'h0, 0);
    step(1, 5'h1B, 1, 1, 1, 11'h7FF, 1);
    checks++; if (busy !== 1'b1 || cpsr_o !== 32'h5000_0011) begin failures++; $display("FAIL busy_ign1 got busy=%b cpsr=%h exp 1 50000011", busy, cpsr_o); end
    step(0, 5'h0, 1, 1, 1, 11'h7FF, 1);
    checks++; if (cpsr_o !== 32'h5000_0093 || spsr_o !== 32'h5000_0011) begin failures++; $display("FAIL busy_ign2 got cpsr=%h spsr=%h exp 50000093 50000011", cpsr_o, spsr_o); end
    step(0, 5'h0, 0, 0, 1, 11'b1111_0_0_00101, 0);
    checks++; if (spsr_o !== 32'hF000_0005 || err !== 1'b0) begin failures++; $display("FAIL spsr_we got spsr=%h err=%b exp f0000005 0", spsr_o, err); end
    step(0, 5'h0, 1, 0, 0, 11'h0, 0);
    checks++; if (cpsr_o !== 32'hF000_0013 || {done, err} !== 2'b11) begin failures++; $display("FAIL ret_bad got cpsr=%h done/err=%b exp f0000013 11", cpsr_o, {done, err}); end
  endtask
  task automatic test_reset_mid();
    step(1, 5'h17, 0, 0, 0, 11'h0, 0);
    #1 nreset = 0;
    model_reset();
    #2;
    checks++; if (cpsr_o !== 32'h0000_00D3 || busy !== 1'b0 || spsr_o !== 32'h0) begin failures++; $display("FAIL reset_mid got cpsr=%h busy=%b spsr=%h exp d3 0 0", cpsr_o, busy, spsr_o); end
    @(negedge clk);
    nreset = 1;
    step(0, 5'h0, 0, 1, 0, 11'b0000_1_1_10111, 0);
    checks++; if (cpsr_o !== 32'h0000_00D7 || spsr_o !== 32'h0) begin failures++; $display("FAIL reset_mid_abt got cpsr=%h spsr=%h exp d7 0", cpsr_o, spsr_o); end
  endtask
  task automatic test_random();
    logic [4:0] pool [8];
    logic [4:0] md;
    pool = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F, 5'h05};
    do_reset();
    for (int n = 0; n < 400; n++) begin
      md = pool[$urandom_range(7)];
      if ($urandom_range(9) == 0) md = 5'($urandom);
      step($urandom_range(99) < 15, pool[$urandom_range(7)], $urandom_range(99) < 15,
           $urandom_range(99) < 40, $urandom_range(99) < 30, {6'($urandom), md}, 1'($urandom));
      checks++; if (cpsr_o !== m_cpsr) begin failures++; $display("FAIL rand_cpsr n=%0d got=%h exp=%h", n, cpsr_o, m_cpsr); end
      checks++; if (spsr_o !== exp_spsr()) begin failures++; $display("FAIL rand_spsr n=%0d got=%h exp=%h", n, spsr_o, exp_spsr()); end
      checks++; if (busy !== (m_stage != 0)) begin failures++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, busy, m_stage != 0); end
      checks++; if (done !== m_done) begin failures++; $display("FAIL rand_done n=%0d got=%b exp=%b", n, done, m_done); end
      checks++; if (err !== m_err) begin failures++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, err, m_err); end
    end
  endtask
  initial begin
    test_reset();
    test_cpsr_write();
    test_exception();
    test_return();
    test_priority();
    test_illegal_mode();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
